updown_counter_5bit: RTL and testbench
======================================

UPDOWN_COUNTER_5BIT -- requirements
Module: updown_counter_5bit

Interface
REQ-001 SHALL have parameter MAX_VAL, default 5'd31: the counter's upper bound; legal range 1..31.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port up, input, 1 bit: direction select; 1 counts up, 0 counts down.
REQ-006 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-007 SHALL have port load_val, input, 5 bits: the value to load.
REQ-008 SHALL have port count, output, 5 bits: registered counter value.
REQ-009 SHALL have port tc, output, 1 bit: terminal count.
REQ-010 SHALL have port ovf, output, 1 bit: sticky wrap/overflow flag, registered.

Function
REQ-011 SHALL apply this priority at each rising clk edge: reset, then load, then en, then hold.
REQ-012 SHALL, on load=1, set count to load_val, clamped to MAX_VAL when load_val > MAX_VAL; en and up are ignored that cycle.
REQ-013 SHALL, on en=1 with up=1, increment count by 1; count == MAX_VAL wraps to 0.
REQ-014 SHALL, on en=1 with up=0, decrement count by 1; count == 0 wraps to MAX_VAL.
REQ-015 SHALL hold count when en=0 and load=0.
REQ-016 SHALL make the new count visible one cycle after en or load is sampled (latency 1).
REQ-017 SHALL drive tc combinationally from the registered count and up: 1 when (up && count==MAX_VAL) or (!up && count==0), regardless of en.
REQ-018 SHALL set ovf on any clock edge where a wrap (or, per REQ-024, an attempted wrap) occurs.
REQ-019 SHALL keep ovf set until reset or load; load clears ovf.
REQ-020 SHALL, when load and a would-be wrap occur in the same cycle, give load precedence and clear ovf.
REQ-021 SHALL, when up changes while en=1, use the new direction on that same edge, with no dead cycle.

Reset
REQ-022 SHALL, when rst_n=0 at a rising clk edge, force count=0 and ovf=0; tc then follows REQ-017 (tc=1 if up=0).
REQ-023 SHALL let reset asserted mid-count override load and en, with no residual state.

Configuration
REQ-024 SHALL, with COUNTER_SAT_EN defined, saturate instead of wrapping: count holds at MAX_VAL (up) or 0 (down), and ovf is still set on the attempted wrap. Without the macro, counting wraps per REQ-013/014.

Structure
REQ-025 SHALL take CNT_W=5 and typedef cnt_t (a CNT_W-bit logic vector) from shared package counter_pkg.
REQ-026 SHALL compute next-state combinationally in this module and hold state in one sub-module, counter_reg_5bit: a 5-bit register with synchronous active-low reset on clk/rst_n.

Verification
REQ-027 SHALL cover: reset held 2 cycles, then released with en=0 -> count=0, ovf=0, tc=1 when up=0.
REQ-028 SHALL cover: MAX_VAL=31, up=1, en=1 for 32 cycles from 0 -> count reaches 31 with tc=1, wraps to 0, ovf=1.
REQ-029 SHALL cover: MAX_VAL=9, load_val=20 -> count=9 next cycle, ovf=0; then up=0, en=1 for 10 cycles -> count reaches 0, wraps to 9, ovf=1.
REQ-030 SHALL cover: load=1, en=1, up=1, load_val=7 at count=31 -> count=7, ovf=0 (load wins).
REQ-031 SHALL cover: COUNTER_SAT_EN defined, count=31, up=1, en=1 for 3 cycles -> count stays 31, ovf=1.
REQ-032 SHALL cover: rst_n=0 asserted at count=12 with en=1 -> count=0 next edge, ovf=0.

Source files
------------

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Types and helpers shared by the 5-bit up/down counter and its register.
//   CNT_W       : counter width (5)
//   cnt_t       : CNT_W-bit counter value
//   clamp_to_max: limits a loaded value to the counter's upper bound
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int CNT_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;

    // A load above the configured bound would leave the counter in a state
    // it can never reach by counting, so the load is pinned to the bound.
    function automatic cnt_t clamp_to_max(input cnt_t val, input cnt_t max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/counter_reg_5bit.sv
// ----------------------------------------------------------------------------
// counter_reg_5bit
// Plain 5-bit state register with synchronous active-low reset.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous reset, active low; clears q to 0
//   d     in   next value
//   q     out  registered value
// ----------------------------------------------------------------------------
module counter_reg_5bit
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  cnt_t d,
    output cnt_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_counter_5bit.sv
// ----------------------------------------------------------------------------
// updown_counter_5bit
// Loadable 5-bit up/down counter with programmable upper bound, terminal
// count and a sticky wrap flag.
// Parameters:
//   MAX_VAL  upper bound of the count range (1..31)
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous reset, active low (count=0, ovf=0)
//   en       in   count enable
//   up       in   direction: 1 = up, 0 = down
//   load     in   synchronous load strobe (beats en)
//   load_val in   value to load, clamped to MAX_VAL
//   count    out  registered count
//   tc       out  terminal count: up at MAX_VAL, or down at 0
//   ovf      out  sticky wrap flag, cleared by reset or load
// Build option:
//   COUNTER_SAT_EN  when defined, the counter saturates at the range ends
//                   instead of wrapping; ovf still flags the attempted wrap.
// Priority each edge: reset, load, en, hold.
// ----------------------------------------------------------------------------
module updown_counter_5bit
    import counter_pkg::*;
#(
    parameter cnt_t MAX_VAL = 5'd31
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic up,
    input  logic load,
    input  cnt_t load_val,
    output cnt_t count,
    output logic tc,
    output logic ovf
);

    cnt_t count_d;
    logic ovf_d;
    logic at_max;
    logic at_zero;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);

    always_comb begin
        count_d = count;
        ovf_d   = ovf;
        if (load) begin
            count_d = clamp_to_max(load_val, MAX_VAL);
            ovf_d   = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef COUNTER_SAT_EN
                    count_d = MAX_VAL;
`else
                    count_d = '0;
`endif
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count + 5'd1;
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_SAT_EN
                    count_d = '0;
`else
                    count_d = MAX_VAL;
`endif
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count - 5'd1;
                end
            end
        end
    end

    counter_reg_5bit u_count_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (count_d),
        .q    (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_d;
        end
    end

    // Follows the live up input, so a direction change shows immediately.
    assign tc = (up && at_max) || (!up && at_zero);

endmodule

// File: tb/tb_updown_counter_5bit.sv
// ----------------------------------------------------------------------------
// tb_updown_counter_5bit
// Two counters (MAX_VAL=31 and MAX_VAL=9) share one set of inputs; each has
// its own expected queue of {ovf,count} filled when a cycle is driven and
// drained one edge later.
// ----------------------------------------------------------------------------
module tb_updown_counter_5bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [4:0] load_val;

    logic [4:0] count_a, count_b;
    logic       tc_a, tc_b;
    logic       ovf_a, ovf_b;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q_a[$];
    logic [5:0] exp_q_b[$];

    // model state {ovf, count}
    logic [5:0] mdl_a = '0;
    logic [5:0] mdl_b = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    updown_counter_5bit #(.MAX_VAL(5'd31)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .ovf(ovf_a)
    );

    updown_counter_5bit #(.MAX_VAL(5'd9)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .ovf(ovf_b)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] model_next(input logic [5:0] cur, input logic [4:0] mx,
                                              input logic r, input logic e, input logic u,
                                              input logic l, input logic [4:0] lv);
        logic [4:0] c;
        logic       o;
        c = cur[4:0];
        o = cur[5];
        if (!r) begin
            c = 5'd0;
            o = 1'b0;
        end else if (l) begin
            c = (lv > mx) ? mx : lv;
            o = 1'b0;
        end else if (e && u) begin
            if (c == mx) begin
`ifdef COUNTER_SAT_EN
                c = mx;
`else
                c = 5'd0;
`endif
                o = 1'b1;
            end else begin
                c = c + 5'd1;
            end
        end else if (e) begin
            if (c == 5'd0) begin
`ifdef COUNTER_SAT_EN
                c = 5'd0;
`else
                c = mx;
`endif
                o = 1'b1;
            end else begin
                c = c - 5'd1;
            end
        end
        return {o, c};
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle, pushes expectations, then checks after the edge.
    task automatic step(input logic r, input logic e, input logic u,
                        input logic l, input logic [4:0] lv);
        logic [5:0] ea, eb;
        rst_n    = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        mdl_a = model_next(mdl_a, 5'd31, r, e, u, l, lv);
        mdl_b = model_next(mdl_b, 5'd9,  r, e, u, l, lv);
        exp_q_a.push_back(mdl_a);
        exp_q_b.push_back(mdl_b);
        @(posedge clk);
        #1;
        if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
            check("queue_empty", 8'd1, 8'd0);
        end else begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
            check("count_a", {3'b0, count_a}, {3'b0, ea[4:0]});
            check("ovf_a",   {7'b0, ovf_a},   {7'b0, ea[5]});
            check("tc_a",    {7'b0, tc_a},
                  {7'b0, (u && ea[4:0] == 5'd31) || (!u && ea[4:0] == 5'd0)});
            check("count_b", {3'b0, count_b}, {3'b0, eb[4:0]});
            check("ovf_b",   {7'b0, ovf_b},   {7'b0, eb[5]});
            check("tc_b",    {7'b0, tc_b},
                  {7'b0, (u && eb[4:0] == 5'd9) || (!u && eb[4:0] == 5'd0)});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = 5'd0;

        // reset for two cycles, then release with en=0, up=0
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

        // count up 32 cycles from 0: A reaches 31 then wraps with ovf
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0);

        // load above bound clamps B to 9, clears ovf; then count down 10
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd20);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);

        // hold with en=0
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);

        // at count 31, load beats a would-be wrap
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd31);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd7);

        // at 31 counting up for 3 cycles (saturates or wraps by build)
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd31);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0);

        // direction flips while enabled
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);

        // reset while counting at 12, with load also requested
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
